// File: rtl/mem_pkg.sv
// Shared types for the cache bank BIST: March C- element and controller state encodings,
// plus small helpers describing each element's direction and data polarity.
package mem_pkg;

    typedef enum logic [2:0] {
        M0,
        M1,
        M2,
        M3,
        M4,
        M5
    } march_elem_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ONLY,
        ST_RD,
        ST_WR,
        ST_RD_ONLY,
        ST_FLUSH,
        ST_DONE
    } bist_state_e;

    localparam logic BIST_MODE_MARCH = 1'b0;
    localparam logic BIST_MODE_FILL  = 1'b1;

    function automatic logic elem_descending(input march_elem_e e);
        return e inside {M3, M4, M5};
    endfunction

    function automatic march_elem_e elem_next(input march_elem_e e);
        march_elem_e n;
        n = M0;
        unique case (e)
            M0: n = M1;
            M1: n = M2;
            M2: n = M3;
            M3: n = M4;
            M4: n = M5;
            default: n = M5;
        endcase
        return n;
    endfunction

    // 1 selects the inverted background for the element's write / read half.
    function automatic logic elem_write_inv(input march_elem_e e);
        return e inside {M1, M3};
    endfunction

    function automatic logic elem_read_inv(input march_elem_e e);
        return e inside {M2, M4};
    endfunction

endpackage

// File: rtl/cc_banks_bist_chk.sv
// Read-data checker: tracks the expected word of each read for one cycle, compares it
// with the bank's returned data and captures the first miscompare until cleared.
module cc_banks_bist_chk #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              cmd_rd,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_exp,
    input  logic [DATA_W-1:0] rdata,
    output logic              mis,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_rdata
);

    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic              fail_q, fail_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_rdata_q, fail_rdata_d;

    always_comb begin
        pend_d       = cmd_rd;
        pend_addr_d  = cmd_rd ? cmd_addr : pend_addr_q;
        exp_d        = cmd_rd ? cmd_exp : exp_q;
        mis          = pend_q && (rdata != exp_q);
        fail_d       = fail_q;
        fail_addr_d  = fail_addr_q;
        fail_rdata_d = fail_rdata_q;
        // Only the first miscompare of a run is recorded; the address survives a clear.
        if (clear) begin
            fail_d = 1'b0;
        end else if (mis && !fail_q) begin
            fail_d       = 1'b1;
            fail_addr_d  = pend_addr_q;
            fail_rdata_d = rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q       <= 1'b0;
            pend_addr_q  <= '0;
            exp_q        <= '0;
            fail_q       <= 1'b0;
            fail_addr_q  <= '0;
            fail_rdata_q <= '0;
        end else begin
            pend_q       <= pend_d;
            pend_addr_q  <= pend_addr_d;
            exp_q        <= exp_d;
            fail_q       <= fail_d;
            fail_addr_q  <= fail_addr_d;
            fail_rdata_q <= fail_rdata_d;
        end
    end

    assign fail       = fail_q;
    assign fail_addr  = fail_addr_q;
    assign fail_rdata = fail_rdata_q;

endmodule

// File: rtl/cc_banks_bist.sv
// BIST / initialisation master for one single-port cache bank: runs March C- or a plain
// background fill over the RW0 port and reports the first read miscompare.
module cc_banks_bist
    import mem_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 64
) (
    input  logic              RW0_clk,
    input  logic              RW0_rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] pattern,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_rdata,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    bist_state_e       state_q, state_d;
    march_elem_e       elem_q, elem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] pat_q, pat_d;
    logic              mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              en_q, en_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              accept;
    logic              desc;
    logic              last_addr;
    logic              mis;
    logic              cmd_rd;
    logic [DATA_W-1:0] cmd_exp;

    assign accept    = (state_q == ST_IDLE) && start;
    assign desc      = elem_descending(elem_q);
    assign last_addr = desc ? (addr_q == '0) : (addr_q == ADDR_MAX);
    assign cmd_rd    = en_q && !wr_q;
    assign cmd_exp   = elem_read_inv(elem_q) ? ~pat_q : pat_q;

    // state_q/elem_q/addr_q always describe the command on the RW0 bus this cycle.
    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        addr_d  = addr_q;
        pat_d   = pat_q;
        mode_d  = mode_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WR_ONLY;
                    elem_d  = M0;
                    addr_d  = '0;
                    pat_d   = pattern;
                    mode_d  = mode;
                end
            end
            ST_WR_ONLY: begin
                if (addr_q == ADDR_MAX) begin
                    if (mode_q == BIST_MODE_FILL) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RD;
                        elem_d  = M1;
                        addr_d  = '0;
                    end
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            ST_RD: begin
                state_d = ST_WR;
            end
            ST_WR: begin
                if (!last_addr) begin
                    state_d = ST_RD;
                    addr_d  = desc ? addr_q - ADDR_ONE : addr_q + ADDR_ONE;
                end else if (elem_q == M4) begin
                    state_d = ST_RD_ONLY;
                    elem_d  = M5;
                    addr_d  = ADDR_MAX;
                end else begin
                    state_d = ST_RD;
                    elem_d  = elem_next(elem_q);
                    addr_d  = elem_descending(elem_next(elem_q)) ? ADDR_MAX : '0;
                end
            end
            ST_RD_ONLY: begin
                if (addr_q == '0) begin
                    state_d = ST_FLUSH;
                end else begin
                    addr_d = addr_q - ADDR_ONE;
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A miscompare lets the command already on the bus finish, then stops the run.
        if (mis && (state_q inside {ST_RD, ST_WR, ST_RD_ONLY, ST_FLUSH})) begin
            state_d = ST_DONE;
        end
        en_d    = state_d inside {ST_WR_ONLY, ST_RD, ST_WR, ST_RD_ONLY};
        wr_d    = state_d inside {ST_WR_ONLY, ST_WR};
        wdata_d = wr_d ? (elem_write_inv(elem_d) ? ~pat_d : pat_d) : '0;
        busy_d  = en_d || (state_d == ST_FLUSH);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            state_q <= ST_IDLE;
            elem_q  <= M0;
            addr_q  <= '0;
            pat_q   <= '0;
            mode_q  <= BIST_MODE_MARCH;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            addr_q  <= addr_d;
            pat_q   <= pat_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            en_q    <= en_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
        end
    end

    cc_banks_bist_chk #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_chk (
        .clk       (RW0_clk),
        .rst_n     (RW0_rst_n),
        .clear     (accept),
        .cmd_rd    (cmd_rd),
        .cmd_addr  (addr_q),
        .cmd_exp   (cmd_exp),
        .rdata     (RW0_rdata),
        .mis       (mis),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_rdata(fail_rdata)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign RW0_addr  = addr_q;
    assign RW0_en    = en_q;
    assign RW0_wmode = wr_q;
    assign RW0_wdata = wdata_q;

endmodule
